// File: rtl/data_out_encoder.sv
// data_out_encoder
//   Serialises a 32-bit word into 1-4 bytes on an 8-bit valid/ready stream.
//   Each byte carries its lane index so the receiving byte-lane decoder can
//   rebuild the original word.
//
// Parameters
//   MSB_FIRST   0: lanes sent 0,1,2,3 ; 1: lanes sent 3,2,1,0
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   word_in     word to transmit, captured on the word handshake
//   num_bytes   byte count minus one, captured with word_in
//   word_valid  word_in/num_bytes valid
//   word_ready  block can accept a word (combinational from byte_ready)
//   byte_out    current byte
//   sel         lane index of byte_out within the captured word
//   byte_valid  byte_out/sel/last valid
//   byte_ready  downstream accepts the byte
//   last        byte_out is the final byte of the word
//   word_done   one-cycle pulse after the final byte is accepted
module data_out_encoder #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic [1:0]  num_bytes,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic [1:0]  sel,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        last,
    output logic        word_done
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [1:0] SEL_INIT = MSB_FIRST ? 2'b11 : 2'b00;

    state_t      state;
    logic [31:0] word_reg;
    logic [1:0]  remaining;
    logic        word_hs;
    logic        byte_hs;
    logic [1:0]  sel_next;

    function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] s);
        return w[{s, 3'b000} +: 8];
    endfunction

    // Accepting the next word in the same cycle as the final byte keeps the
    // byte stream gap-free across word boundaries.
    assign word_ready = (state == IDLE) || ((state == SEND) && last && byte_ready);
    assign word_hs    = word_valid && word_ready;
    assign byte_hs    = byte_valid && byte_ready;
    assign sel_next   = MSB_FIRST ? (sel - 2'd1) : (sel + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_reg   <= 32'h0000_0000;
            remaining  <= 2'b00;
            byte_out   <= 8'h00;
            sel        <= 2'b00;
            byte_valid <= 1'b0;
            last       <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            word_done <= byte_hs && last;
            if (word_hs) begin
                // Covers both a fresh word from IDLE and a back-to-back word
                // accepted alongside the final byte of the previous one.
                state      <= SEND;
                word_reg   <= word_in;
                remaining  <= num_bytes;
                sel        <= SEL_INIT;
                byte_out   <= lane_of(word_in, SEL_INIT);
                last       <= (num_bytes == 2'b00);
                byte_valid <= 1'b1;
            end else if (byte_hs) begin
                if (last) begin
                    state      <= IDLE;
                    byte_valid <= 1'b0;
                    last       <= 1'b0;
                end else begin
                    // remaining never underflows here: last is set once it hits 0
                    sel       <= sel_next;
                    byte_out  <= lane_of(word_reg, sel_next);
                    remaining <= remaining - 2'd1;
                    last      <= (remaining == 2'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_out_encoder.sv
module tb_data_out_encoder;

    typedef struct {
        logic [7:0] b0;
        logic [1:0] s0;
        logic [7:0] b1;
        logic [1:0] s1;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word_in = 32'h0;
    logic [1:0]  num_bytes = 2'b00;
    logic        word_valid = 1'b0;
    logic        byte_ready = 1'b1;

    logic        wr [2];
    logic [7:0]  bo [2];
    logic [1:0]  sl [2];
    logic        bv [2];
    logic        ls [2];
    logic        wd [2];

    int checks = 0;
    int errors = 0;
    bit rand_br = 1'b0;

    exp_t q[$];

    data_out_encoder #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .num_bytes(num_bytes),
        .word_valid(word_valid), .word_ready(wr[0]), .byte_out(bo[0]), .sel(sl[0]),
        .byte_valid(bv[0]), .byte_ready(byte_ready), .last(ls[0]), .word_done(wd[0])
    );

    data_out_encoder #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .num_bytes(num_bytes),
        .word_valid(word_valid), .word_ready(wr[1]), .byte_out(bo[1]), .sel(sl[1]),
        .byte_valid(bv[1]), .byte_ready(byte_ready), .last(ls[1]), .word_done(wd[1])
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a k-byte word becomes k entries, lane i (ascending)
    // for the LSB-first instance and lane 3-i for the MSB-first instance.
    task automatic push_word(input logic [31:0] w, input logic [1:0] nb);
        exp_t e;
        for (int k = 0; k <= int'(nb); k++) begin
            e.b0 = w[8*k +: 8];
            e.s0 = 2'(k);
            e.b1 = w[8*(3-k) +: 8];
            e.s1 = 2'(3 - k);
            e.l  = (k == int'(nb));
            q.push_back(e);
        end
    endtask

    // Monitor / scoreboard
    bit         done_exp = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] pb [2];
    logic [1:0] ps [2];
    logic       pl [2];

    always @(negedge clk) begin
        bit   exp_wr, exp_bv, hs, new_done;
        exp_t f;
        if (!rst_n) begin
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_bv   = (q.size() != 0);
            exp_wr   = (q.size() == 0) || (q.size() == 1 && byte_ready);
            hs       = exp_bv && byte_ready;
            new_done = 1'b0;
            if (exp_bv) f = q[0];
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("word_ready[%0d]", i), 32'(wr[i]), 32'(exp_wr));
                chk($sformatf("byte_valid[%0d]", i), 32'(bv[i]), 32'(exp_bv));
                chk($sformatf("word_done[%0d]", i), 32'(wd[i]), 32'(done_exp));
                if (prev_stall) begin
                    chk($sformatf("stall_byte[%0d]", i), 32'(bo[i]), 32'(pb[i]));
                    chk($sformatf("stall_sel[%0d]", i), 32'(sl[i]), 32'(ps[i]));
                    chk($sformatf("stall_last[%0d]", i), 32'(ls[i]), 32'(pl[i]));
                end
                if (hs) begin
                    chk($sformatf("byte[%0d]", i), 32'(bo[i]), 32'(i == 0 ? f.b0 : f.b1));
                    chk($sformatf("sel[%0d]", i), 32'(sl[i]), 32'(i == 0 ? f.s0 : f.s1));
                    chk($sformatf("last[%0d]", i), 32'(ls[i]), 32'(f.l));
                end
                pb[i] = bo[i];
                ps[i] = sl[i];
                pl[i] = ls[i];
            end
            if (hs) begin
                new_done = f.l;
                void'(q.pop_front());
            end
            prev_stall = exp_bv && !byte_ready;
            done_exp   = new_done;
        end
    end

    // Downstream back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            byte_ready = rand_br ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic put(input logic [31:0] w, input logic [1:0] nb);
        bit hs = 1'b0;
        int n = 0;
        word_in    = w;
        num_bytes  = nb;
        word_valid = 1'b1;
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = wr[0];
            @(posedge clk);
            if (hs) push_word(w, nb);
            #1;
            n++;
        end
        if (!hs) chk("put_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        word_valid = 1'b0;
        while ((q.size() != 0 || bv[0] || bv[1]) && n < 1000) begin
            @(posedge clk);
            #1;
            word_in   = $urandom;
            num_bytes = 2'($urandom_range(0, 3));
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_byte_out[%0d]", i), 32'(bo[i]), 32'h00);
            chk($sformatf("rst_sel[%0d]", i), 32'(sl[i]), 32'h0);
            chk($sformatf("rst_byte_valid[%0d]", i), 32'(bv[i]), 32'h0);
            chk($sformatf("rst_last[%0d]", i), 32'(ls[i]), 32'h0);
            chk($sformatf("rst_word_done[%0d]", i), 32'(wd[i]), 32'h0);
            chk($sformatf("rst_word_ready[%0d]", i), 32'(wr[i]), 32'h1);
        end
    endtask

    initial begin
        #2;
        chk_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word, both lane orders
        put(32'hDDCC_BBAA, 2'd3);
        drain();

        // Single byte followed immediately by another word
        put(32'h0000_0055, 2'd0);
        put(32'h1234_5678, 2'd2);
        drain();

        // Back-to-back words with continuous word_valid
        put(32'h4433_2211, 2'd3);
        put(32'h8877_6655, 2'd3);
        drain();

        // Random traffic with random back-pressure
        rand_br = 1'b1;
        for (int t = 0; t < 40; t++) begin
            put($urandom, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                word_valid = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk);
                    #1;
                    word_in = $urandom;
                end
            end
        end
        drain();

        // Reset asserted after the second byte of a word
        rand_br = 1'b0;
        put(32'hA1B2_C3D4, 2'd3);
        word_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        put(32'hCAFE_F00D, 2'd3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
